// File: rtl/ram_arbiter_pkg.sv
// Shared types for the two-master RAM arbiter: FSM state encoding and requester ids.
package ram_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR      = 3'd1,
    ST_RD_ADDR = 3'd2,
    ST_RD_DATA = 3'd3,
    ST_RESP    = 3'd4
  } state_e;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  function automatic logic other_id(input logic id);
    return ~id;
  endfunction

endpackage

// File: rtl/ram_arbiter_if.sv
// Request/response channel between one master and the RAM arbiter.
interface ram_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
);

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata
  );

endinterface

// File: rtl/ram_arbiter_rr_arbiter2.sv
// Two-way round-robin grant selection; purely combinational.
module rr_arbiter2
  import ram_ctrl_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       grant_valid,
  output logic       grant_id
);

  // on a tie the master that did not win last time is served
  always_comb begin
    grant_valid = |req;
    grant_id    = M0;
    if (req == 2'b11) begin
      grant_id = other_id(last_grant);
    end else if (req[1]) begin
      grant_id = M1;
    end else begin
      grant_id = M0;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Serialises two masters onto a single-port RAM, sequencing cs/we/oe and the bus turnaround.
module ram_arbiter
  import ram_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  ram_arbiter_if.slave          m0,
  ram_arbiter_if.slave          m1,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic                  ram_cs,
  output logic                  ram_we,
  output logic                  ram_oe,
  inout  wire  [DATA_WIDTH-1:0] ram_data
);

  state_e                state_q, state_d;
  logic                  last_grant_q;
  logic                  id_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  logic                  grant_valid_s;
  logic                  grant_id_s;
  logic                  accept_s;
  logic                  sel_we_s;
  logic [ADDR_WIDTH-1:0] sel_addr_s;
  logic [DATA_WIDTH-1:0] sel_wdata_s;
  logic                  drive_s;

  rr_arbiter2 u_arb (
    .req         ({m1.req_valid, m0.req_valid}),
    .last_grant  (last_grant_q),
    .grant_valid (grant_valid_s),
    .grant_id    (grant_id_s)
  );

  assign accept_s     = (state_q == ST_IDLE) && grant_valid_s && !rst;
  assign m0.req_ready = accept_s && (grant_id_s == M0);
  assign m1.req_ready = accept_s && (grant_id_s == M1);

  always_comb begin
    sel_we_s    = m0.req_we;
    sel_addr_s  = m0.req_addr;
    sel_wdata_s = m0.req_wdata;
    if (grant_id_s == M1) begin
      sel_we_s    = m1.req_we;
      sel_addr_s  = m1.req_addr;
      sel_wdata_s = m1.req_wdata;
    end else begin
      sel_we_s    = m0.req_we;
      sel_addr_s  = m0.req_addr;
      sel_wdata_s = m0.req_wdata;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          state_d = sel_we_s ? ST_WR : ST_RD_ADDR;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WR:      state_d = ST_RESP;
      ST_RD_ADDR: state_d = ST_RD_DATA;
      ST_RD_DATA: state_d = ST_RESP;
      ST_RESP:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // strobes come straight off the state register so reset clears them at once
  always_comb begin
    ram_cs  = 1'b0;
    ram_we  = 1'b0;
    ram_oe  = 1'b0;
    drive_s = 1'b0;
    case (state_q)
      ST_WR: begin
        ram_cs  = 1'b1;
        ram_we  = 1'b1;
        drive_s = 1'b1;
      end
      ST_RD_ADDR, ST_RD_DATA: begin
        ram_cs = 1'b1;
        ram_oe = 1'b1;
      end
      default: begin
        ram_cs  = 1'b0;
        ram_we  = 1'b0;
        ram_oe  = 1'b0;
        drive_s = 1'b0;
      end
    endcase
  end

  assign ram_address  = addr_q;
  assign ram_data     = drive_s ? wdata_q : {DATA_WIDTH{1'bz}};

  assign m0.rsp_valid = (state_q == ST_RESP) && (id_q == M0);
  assign m1.rsp_valid = (state_q == ST_RESP) && (id_q == M1);
  assign m0.rsp_rdata = rdata_q;
  assign m1.rsp_rdata = rdata_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      last_grant_q <= M1;
      id_q         <= M0;
      addr_q       <= {ADDR_WIDTH{1'b0}};
      wdata_q      <= {DATA_WIDTH{1'b0}};
      rdata_q      <= {DATA_WIDTH{1'b0}};
    end else begin
      state_q <= state_d;
      if (accept_s) begin
        last_grant_q <= grant_id_s;
        id_q         <= grant_id_s;
        addr_q       <= sel_addr_s;
        wdata_q      <= sel_wdata_s;
      end
      if (state_q == ST_RD_DATA) begin
        rdata_q <= ram_data;
      end
    end
  end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-requester round-robin controller for the single-port `ram` (cs/we/oe strobes, bidirectional data bus). It serialises read and write requests from two masters, sequences the RAM strobes, and owns the tri-state turnaround on the shared data bus. Typical masters are the message loader (writes) and the SipHash core (reads), which share one message/key store.

## Interface
Parameters:
- `DATA_WIDTH`, 32, RAM word width.
- `ADDR_WIDTH`, 10, RAM address width; the block passes it through unchanged.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `mN_req_valid`  in  1  request from master N (N = 0, 1).
- `mN_req_ready`  out  1  request accepted when valid && ready.
- `mN_req_we`  in  1  1 = write, 0 = read.
- `mN_req_addr`  in  ADDR_WIDTH  word address.
- `mN_req_wdata`  in  DATA_WIDTH  write data.
- `mN_rsp_valid`  out  1  one-cycle completion pulse.
- `mN_rsp_rdata`  out  DATA_WIDTH  read data; valid while `mN_rsp_valid`=1 after a read.
- `ram_address`  out  ADDR_WIDTH  to RAM `address`.
- `ram_cs`, `ram_we`, `ram_oe`  out  1  to RAM strobes.
- `ram_data`  inout  DATA_WIDTH  to RAM `data`.

## Operation
- FSM states: IDLE, WR, RD_ADDR, RD_DATA, RESP.
- IDLE: the arbiter picks a grant from the valids.
  - `mN_req_ready` = (state == IDLE) && grant == N && !rst. Ready depends combinationally on valid, so masters must not gate valid on ready.
- Arbitration is 2-way round-robin on the `last_grant` register.
  - If only one master is valid, it wins.
  - If both are valid, the master other than `last_grant` wins.
  - `last_grant` updates on accept and resets to 1, so m0 wins the first tie.
- On accept, the block latches the addr, we, wdata and requester id. It loads `ram_address` from the latched addr, which holds until the next accept. Next state is WR when we = 1, otherwise RD_ADDR.
- WR (1 cycle):
  - `ram_cs`=1, `ram_we`=1, `ram_oe`=0.
  - `ram_data` is driven with the latched wdata.
  - The RAM writes on the closing edge. Next state: RESP.
- RD_ADDR (1 cycle):
  - `ram_cs`=1, `ram_oe`=1, `ram_we`=0; `ram_data` is released (Z).
  - The RAM registers `data_out` on the closing edge. Next state: RD_DATA.
- RD_DATA (1 cycle):
  - Same strobes as RD_ADDR.
  - The RAM drives the bus; the block captures `ram_data` into the read-data register on the closing edge. Next state: RESP.
- RESP (1 cycle): `mN_rsp_valid`=1 for the latched requester only. Next state: IDLE.
- `mN_rsp_rdata` carries the read-data register to both masters. It holds its value until the next read capture, and keeps its old value after a write.
- Bus rule: the block drives `ram_data` only in WR; in every other state it is Z. `ram_we` and `ram_oe` are never 1 together.
- Reset values: state IDLE, all strobes 0, `ram_address` 0, `ram_data` Z, both `rsp_valid` 0, rdata register 0, `last_grant` 1.
- Reset mid-operation takes effect immediately (asynchronous):
  - strobes drop to 0 and the bus is released;
  - the in-flight request is discarded with no rsp pulse;
  - any partial RAM write is the requester's concern.

## Timing
- Write: accept at edge T0 → RAM write at T1 → `rsp_valid` high during cycle T1–T2. Next accept is no earlier than T3. Throughput: 1 write per 3 cycles.
- Read: accept at T0 → data captured at T2 → `rsp_valid` and rdata during cycle T2–T3. Next accept is no earlier than T4. Throughput: 1 read per 4 cycles.
- Request inputs are sampled only at the accept edge. Masters may change them freely afterwards.
- `ram_address` is registered; RAM strobes and bus enable are decoded from the state register.

## Structure
- Package `ram_ctrl_pkg`: state encoding localparams (IDLE, WR, RD_ADDR, RD_DATA, RESP) and requester-id constants (M0, M1).
- Sub-module `rr_arbiter2`:
  - inputs: `req[1:0]`, `last_grant`;
  - outputs: `grant_valid`, `grant_id`;
  - purely combinational.
- Top level contains the FSM, the latches, the read-data register and the tri-state assign.

## Test plan
- Reset → all outputs at reset values, bus Z. Release reset with m0 idle → no strobes.
- m0 writes 0xDEADBEEF to address 0x005, then reads 0x005 → write pulse at T1, `rsp_valid` at T1–T2, read returns 0xDEADBEEF in cycle T2–T3.
- Both masters valid continuously from reset, each with its own address → grants alternate m0, m1, m0, …. Each `rsp_valid` reaches only its own requester.
- Back-to-back m1 reads of 0x000 and 0x3FF (boundaries) preloaded with 0x11111111 and 0x22222222 → correct data. The bus is never driven by the block during reads (checked by a contention monitor).
- Assert `rst` during RD_DATA → strobes 0 the same cycle, no rsp pulse. The next request completes normally.
- m0 write then immediate m1 read of the same address → m1 reads the new value. `ram_we`&&`ram_oe` is never true (assertion).
